// File: rtl/sram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the asynchronous-SRAM arbiter slice.
//   arbState_e        : controller FSM states
//   STROBE_CYCLES_DEF : default low width of mem_we / mem_oe in clk cycles
//   STAT_W            : width of the optional transfer counters
// Optional feature: SRAM_ARB_STATS_EN (see sram_arbiter.sv).
// ----------------------------------------------------------------------------
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SETUP  = 3'd1,
    WR_STROBE = 3'd2,
    WR_HOLD   = 3'd3,
    RD_SETUP  = 3'd4,
    RD_STROBE = 3'd5,
    RD_DONE   = 3'd6
  } arbState_e;

  localparam int STROBE_CYCLES_DEF = 2;
  localparam int STAT_W            = 16;

endpackage

// File: rtl/sram_rr_arb.sv
// ----------------------------------------------------------------------------
// sram_rr_arb
// Two-way round-robin arbiter between the write and read requesters.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   wrReq_i        : write side requesting
//   rdReq_i        : read side requesting
//   accept_i       : controller is idle and will take the granted side now
//   grantWr_o      : write side wins this cycle
//   grantRd_o      : read side wins this cycle
// After reset the last grant is "read", so the write side wins the first tie.
// ----------------------------------------------------------------------------
module sram_rr_arb (
  input  logic clk_i,
  input  logic reset_i,
  input  logic wrReq_i,
  input  logic rdReq_i,
  input  logic accept_i,
  output logic grantWr_o,
  output logic grantRd_o
);

  logic lastWr_q, lastWr_d;

  // Grant is purely combinational from the requests and the remembered
  // winner; the winner is only updated when the controller actually takes
  // a transfer, so a grant that is not accepted never shifts priority.
  always_comb begin
    grantWr_o = 1'b0;
    grantRd_o = 1'b0;
    if (wrReq_i && rdReq_i) begin
      grantWr_o = !lastWr_q;
      grantRd_o = lastWr_q;
    end else begin
      grantWr_o = wrReq_i;
      grantRd_o = rdReq_i;
    end
    lastWr_d = lastWr_q;
    if (accept_i && (wrReq_i || rdReq_i)) begin
      lastWr_d = grantWr_o;
    end
  end

  // Remembered winner register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lastWr_q <= 1'b0;
    end else begin
      lastWr_q <= lastWr_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// ----------------------------------------------------------------------------
// sram_arbiter
// Shares one asynchronous SRAM between a write requester and a read
// requester, generating setup / strobe / hold timing for the SRAM.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data   : write request (held until wr_ack)
//   wr_ack                   : one-cycle pulse, write completed
//   rd_req/rd_addr           : read request (held until rd_ack)
//   rd_ack/rd_data           : one-cycle pulse, registered read data
//   mem_addr                 : SRAM address
//   mem_data                 : SRAM bidirectional data bus
//   mem_we, mem_oe           : active-low SRAM write strobe / output enable
//   wr_count, rd_count       : acked transfer counters (only with
//                              SRAM_ARB_STATS_EN defined)
// Parameters: ADDR_W, DATA_W, STROBE_CYCLES (1..15).
// ----------------------------------------------------------------------------
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int STROBE_CYCLES = STROBE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_oe
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] wr_count,
  output logic [STAT_W-1:0] rd_count
`endif
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  arbState_e         state_q, state_d;
  logic [3:0]        strobeCnt_q, strobeCnt_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              grantWr, grantRd;
  logic              driveEn;

  sram_rr_arb uArb (
    .clk_i     (clk),
    .reset_i   (reset),
    .wrReq_i   (wr_req),
    .rdReq_i   (rd_req),
    .accept_i  (state_q == IDLE),
    .grantWr_o (grantWr),
    .grantRd_o (grantRd)
  );

  // Next-state logic. Address and write data are captured at accept so the
  // SRAM sees them stable for the whole transfer even if the requester
  // drops its request early; once accepted a transfer always runs to ack.
  always_comb begin
    state_d     = state_q;
    strobeCnt_d = strobeCnt_q;
    memAddr_d   = memAddr_q;
    wrData_d    = wrData_q;
    rdData_d    = rdData_q;
    case (state_q)
      IDLE: begin
        if (grantWr) begin
          state_d   = WR_SETUP;
          memAddr_d = wr_addr;
          wrData_d  = wr_data;
        end else if (grantRd) begin
          state_d   = RD_SETUP;
          memAddr_d = rd_addr;
        end
      end
      WR_SETUP: begin
        state_d     = WR_STROBE;
        strobeCnt_d = '0;
      end
      WR_STROBE: begin
        if (strobeCnt_q == STROBE_LAST) begin
          state_d = WR_HOLD;
        end else begin
          strobeCnt_d = strobeCnt_q + 4'd1;
        end
      end
      WR_HOLD: state_d = IDLE;
      RD_SETUP: begin
        state_d     = RD_STROBE;
        strobeCnt_d = '0;
      end
      RD_STROBE: begin
        if (strobeCnt_q == STROBE_LAST) begin
          state_d  = RD_DONE;
          rdData_d = mem_data;
        end else begin
          strobeCnt_d = strobeCnt_q + 4'd1;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Write data is not reset: it is only
  // visible on the bus while a write is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      strobeCnt_q <= '0;
      memAddr_q   <= '0;
      rdData_q    <= '0;
    end else begin
      state_q     <= state_d;
      strobeCnt_q <= strobeCnt_d;
      memAddr_q   <= memAddr_d;
      rdData_q    <= rdData_d;
    end
    wrData_q <= wrData_d;
  end

  // Strobes and acks decode straight from the registered state, so
  // mem_we and mem_oe can never be low together.
  assign driveEn  = (state_q == WR_SETUP) || (state_q == WR_STROBE) ||
                    (state_q == WR_HOLD);
  assign mem_we   = (state_q != WR_STROBE);
  assign mem_oe   = (state_q != RD_STROBE);
  assign wr_ack   = (state_q == WR_HOLD);
  assign rd_ack   = (state_q == RD_DONE);
  assign mem_addr = memAddr_q;
  assign rd_data  = rdData_q;
  assign mem_data = driveEn ? wrData_q : 'z;

`ifdef SRAM_ARB_STATS_EN
  logic [STAT_W-1:0] wrCount_q, wrCount_d;
  logic [STAT_W-1:0] rdCount_q, rdCount_d;

  // Counters advance on each ack and wrap naturally at the top.
  always_comb begin
    wrCount_d = wrCount_q + (wr_ack ? STAT_W'(1) : STAT_W'(0));
    rdCount_d = rdCount_q + (rd_ack ? STAT_W'(1) : STAT_W'(0));
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrCount_q <= '0;
      rdCount_q <= '0;
    end else begin
      wrCount_q <= wrCount_d;
      rdCount_q <= rdCount_d;
    end
  end

  assign wr_count = wrCount_q;
  assign rd_count = rdCount_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_arbiter
// Three arbiter instances (STROBE_CYCLES = 2, 1, 15), each with a small
// falling-edge-capture SRAM model on its bus. Instance 0 carries directed
// and randomized traffic checked against a flat memory array; instances
// 1 and 2 check strobe widths and ack latency at the extremes.
// Counter checks are compiled when SRAM_ARB_STATS_EN is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int N = 3;
  localparam int SV [N] = '{2, 1, 15};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        wrReq [N];
  logic        rdReq [N];
  logic [15:0] wrAddr [N];
  logic [15:0] wrData [N];
  logic [15:0] rdAddr [N];
  logic        wrAck [N];
  logic        rdAck [N];
  logic        memWe [N];
  logic        memOe [N];
  logic [15:0] rdData [N];
  logic [15:0] memAddr [N];
  logic [15:0] memBus [N];
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] wrCount [N];
  logic [15:0] rdCount [N];
`endif

  logic [15:0] refMem [256];
  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One DUT plus SRAM model and bus monitors per strobe setting.
  for (genvar k = 0; k < N; k++) begin : g
    wire  [15:0] memData;
    logic [15:0] sram [256];
    logic [15:0] sramOut;
    int          weLow = 0;
    int          oeLow = 0;

    sram_arbiter #(.ADDR_W(16), .DATA_W(16), .STROBE_CYCLES(SV[k])) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_req   (wrReq[k]),
      .wr_addr  (wrAddr[k]),
      .wr_data  (wrData[k]),
      .wr_ack   (wrAck[k]),
      .rd_req   (rdReq[k]),
      .rd_addr  (rdAddr[k]),
      .rd_ack   (rdAck[k]),
      .rd_data  (rdData[k]),
      .mem_addr (memAddr[k]),
      .mem_data (memData),
      .mem_we   (memWe[k]),
      .mem_oe   (memOe[k])
`ifdef SRAM_ARB_STATS_EN
      ,
      .wr_count (wrCount[k]),
      .rd_count (rdCount[k])
`endif
    );

    pulldown (memData);
    assign sramOut   = sram[memAddr[k][7:0]];
    assign memData   = memOe[k] ? 16'bz : sramOut;
    assign memBus[k] = memData;

    initial begin
      for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
    end

    always @(negedge memWe[k]) sram[memAddr[k][7:0]] <= memData;

    always @(negedge clk) begin
      if (reset) begin
        weLow = 0;
        oeLow = 0;
      end else begin
        checkOutput($sformatf("we_oe_excl%0d", k), 32'(memWe[k] | memOe[k]), 32'd1);
        if (!memOe[k]) checkOutput($sformatf("bus_rd%0d", k), 32'(memBus[k]), 32'(sramOut));
        if (!memWe[k]) weLow++;
        else if (weLow != 0) begin
          checkOutput($sformatf("we_width%0d", k), 32'(weLow), 32'(SV[k]));
          weLow = 0;
        end
        if (!memOe[k]) oeLow++;
        else if (oeLow != 0) begin
          checkOutput($sformatf("oe_width%0d", k), 32'(oeLow), 32'(SV[k]));
          oeLow = 0;
        end
      end
    end
  end

  // One complete transfer on instance k, started from an idle controller.
  // lat counts cycles from the accepting idle cycle to the ack cycle.
  task automatic applyStimulus(input int k, input bit isWr, input logic [15:0] addr,
                               input logic [15:0] data, output int lat,
                               output logic [15:0] rdVal);
    @(negedge clk);
    if (isWr) begin
      wrReq[k] = 1'b1; wrAddr[k] = addr; wrData[k] = data;
    end else begin
      rdReq[k] = 1'b1; rdAddr[k] = addr;
    end
    lat   = 0;
    rdVal = '0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(isWr ? wrAck[k] : rdAck[k]) && lat < 100);
    if (!isWr) rdVal = rdData[k];
    if (isWr) wrReq[k] = 1'b0;
    else rdReq[k] = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, nAck, cyc, prevCyc, sawAck;
    logic [15:0] v;

    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      wrReq[k] = 1'b0; rdReq[k] = 1'b0;
      wrAddr[k] = '0; wrData[k] = '0; rdAddr[k] = '0;
    end
    for (int i = 0; i < 256; i++) refMem[i] = 16'h0000;

    // Reset state of every instance.
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("rst_we%0d", k), 32'(memWe[k]), 32'd1);
      checkOutput($sformatf("rst_oe%0d", k), 32'(memOe[k]), 32'd1);
      checkOutput($sformatf("rst_acks%0d", k), 32'({wrAck[k], rdAck[k]}), 32'd0);
      checkOutput($sformatf("rst_rdata%0d", k), 32'(rdData[k]), 32'd0);
      checkOutput($sformatf("rst_addr%0d", k), 32'(memAddr[k]), 32'd0);
      checkOutput($sformatf("rst_bus%0d", k), 32'(memBus[k]), 32'd0);
`ifdef SRAM_ARB_STATS_EN
      checkOutput($sformatf("rst_cnt%0d", k), 32'({wrCount[k], rdCount[k]}), 32'd0);
`endif
    end
    reset = 1'b0;

    // Write then read back, STROBE_CYCLES = 2.
    applyStimulus(0, 1'b1, 16'h0010, 16'hBEEF, lat, v);
    refMem[16'h10] = 16'hBEEF;
    checkOutput("wr_lat", 32'(lat), 32'd4);
    checkOutput("wr_sram", 32'(g[0].sram[16'h10]), 32'hBEEF);
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000, lat, v);
    checkOutput("rd_lat", 32'(lat), 32'd4);
    checkOutput("rd_data", 32'(v), 32'hBEEF);
    repeat (3) @(negedge clk);
    checkOutput("rd_hold", 32'(rdData[0]), 32'hBEEF);

    // Strobe extremes: 1 and 15 cycles.
    for (int k = 1; k < N; k++) begin
      logic [15:0] d;
      d = 16'(16'hA000 + k);
      reset = 1'b0;
      applyStimulus(k, 1'b1, 16'h0042, d, lat, v);
      checkOutput($sformatf("wr_lat%0d", k), 32'(lat), 32'(2 + SV[k]));
      applyStimulus(k, 1'b0, 16'h0042, 16'h0000, lat, v);
      checkOutput($sformatf("rd_lat%0d", k), 32'(lat), 32'(2 + SV[k]));
      checkOutput($sformatf("rd_data%0d", k), 32'(v), 32'(d));
    end

    // Contention from reset: W,R,W,R with one idle cycle between transfers.
    @(negedge clk);
    reset = 1'b1;
    wrReq[0] = 1'b1; wrAddr[0] = 16'h0020; wrData[0] = 16'h1234;
    rdReq[0] = 1'b1; rdAddr[0] = 16'h0020;
    @(negedge clk);
    reset = 1'b0;
    nAck = 0; cyc = 0; prevCyc = 0;
    while (nAck < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (wrAck[0] || rdAck[0]) begin
        checkOutput($sformatf("cont_side%0d", nAck), 32'(rdAck[0]), 32'(nAck % 2));
        if (nAck == 0) checkOutput("cont_first", 32'(cyc), 32'd4);
        else checkOutput($sformatf("cont_gap%0d", nAck), 32'(cyc - prevCyc), 32'd5);
        if (rdAck[0]) checkOutput("cont_rdata", 32'(rdData[0]), 32'h1234);
        prevCyc = cyc;
        nAck++;
        if (nAck == 4) begin
          wrReq[0] = 1'b0; rdReq[0] = 1'b0;
        end
      end
    end
    checkOutput("cont_acks", 32'(nAck), 32'd4);
    refMem[16'h20] = 16'h1234;

    // Reset in the second write-strobe cycle aborts the write.
    applyStimulus(0, 1'b1, 16'h0030, 16'h1111, lat, v);
    @(negedge clk);
    wrReq[0] = 1'b1; wrAddr[0] = 16'h0030; wrData[0] = 16'h2222;
    repeat (3) @(negedge clk);
    checkOutput("abort_strobe", 32'(memWe[0]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_we", 32'(memWe[0]), 32'd1);
    checkOutput("abort_bus", 32'(memBus[0]), 32'd0);
    checkOutput("abort_ack", 32'(wrAck[0]), 32'd0);
    checkOutput("abort_addr", 32'(memAddr[0]), 32'd0);
    checkOutput("abort_rdata", 32'(rdData[0]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wrReq[0] = 1'b0;
    sawAck = 0;
    repeat (10) begin
      @(negedge clk);
      if (wrAck[0]) sawAck++;
    end
    checkOutput("abort_noack", 32'(sawAck), 32'd0);
    checkOutput("abort_sram", 32'(g[0].sram[16'h30]), 32'h2222);
    refMem[16'h30] = 16'h2222;

    // Randomized concurrent traffic on instance 0.
    fork
      begin
        for (int t = 0; t < 30; t++) begin
          int wl;
          logic [15:0] a, d, dummy;
          a = 16'($urandom_range(0, 15));
          d = 16'($urandom);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          applyStimulus(0, 1'b1, a, d, wl, dummy);
          refMem[a[7:0]] = d;
          checkOutput("rand_wr_sram", 32'(g[0].sram[a[7:0]]), 32'(d));
          checkOutput("rand_wr_lat", 32'(wl <= 5 + 2 * SV[0]), 32'd1);
        end
      end
      begin
        for (int t = 0; t < 30; t++) begin
          int rl;
          logic [15:0] a, got;
          a = 16'($urandom_range(0, 15));
          repeat ($urandom_range(0, 3)) @(negedge clk);
          applyStimulus(0, 1'b0, a, 16'h0000, rl, got);
          checkOutput("rand_rd_data", 32'(got), 32'(refMem[a[7:0]]));
          checkOutput("rand_rd_lat", 32'(rl <= 5 + 2 * SV[0]), 32'd1);
        end
      end
    join

`ifdef SRAM_ARB_STATS_EN
    applyReset();
    for (int t = 0; t < 3; t++) applyStimulus(0, 1'b1, 16'(t), 16'(t + 7), lat, v);
    for (int t = 0; t < 2; t++) applyStimulus(0, 1'b0, 16'(t), 16'h0000, lat, v);
    @(negedge clk);
    checkOutput("stat_wr", 32'(wrCount[0]), 32'd3);
    checkOutput("stat_rd", 32'(rdCount[0]), 32'd2);
    g[0].dut.wrCount_q = 16'hFFFF;
    applyStimulus(0, 1'b1, 16'h0005, 16'h5555, lat, v);
    @(negedge clk);
    checkOutput("stat_wrap", 32'(wrCount[0]), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, the SRAM data width.
REQ-003 SHALL have parameter STROBE_CYCLES, default 2, the low width of mem_we/mem_oe in clk cycles; legal range 1..15.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_req  input  1  write request, held high until wr_ack.
REQ-007 SHALL have port wr_addr  input  ADDR_W  write address, stable while wr_req high.
REQ-008 SHALL have port wr_data  input  DATA_W  write data, stable while wr_req high.
REQ-009 SHALL have port wr_ack  output  1  one-cycle pulse, write completed.
REQ-010 SHALL have port rd_req  input  1  read request, held high until rd_ack.
REQ-011 SHALL have port rd_addr  input  ADDR_W  read address, stable while rd_req high.
REQ-012 SHALL have port rd_ack  output  1  one-cycle pulse, rd_data valid.
REQ-013 SHALL have port rd_data  output  DATA_W  registered read data, held until next read completes.
REQ-014 SHALL have port mem_addr  output  ADDR_W  SRAM address.
REQ-015 SHALL have port mem_data  inout  DATA_W  SRAM bidirectional data bus.
REQ-016 SHALL have port mem_we  output  1  active-low SRAM write strobe; SRAM captures on falling edge.
REQ-017 SHALL have port mem_oe  output  1  active-low SRAM output enable; SRAM drives bus while low.

Function
REQ-018 SHALL implement FSM states IDLE, WR_SETUP, WR_STROBE, WR_HOLD, RD_SETUP, RD_STROBE, RD_DONE, all registered.
REQ-019 SHALL in IDLE with any request pending grant one requester and move to WR_SETUP or RD_SETUP next cycle.
REQ-020 SHALL arbitrate round-robin: both pending -> grant the side not granted last; only one pending -> grant it.
REQ-021 SHALL write: WR_SETUP 1 cycle (mem_addr=wr_addr, drive wr_data, mem_we=1); WR_STROBE exactly STROBE_CYCLES cycles mem_we=0; WR_HOLD 1 cycle mem_we=1, data still driven, wr_ack=1; then IDLE.
REQ-022 SHALL read: RD_SETUP 1 cycle (mem_addr=rd_addr, mem_oe=1, bus released); RD_STROBE exactly STROBE_CYCLES cycles mem_oe=0; register mem_data into rd_data on last RD_STROBE edge; RD_DONE 1 cycle mem_oe=1, rd_ack=1; then IDLE.
REQ-023 SHALL drive mem_data only in WR_SETUP/WR_STROBE/WR_HOLD, else high-Z; never drive while mem_oe=0.
REQ-024 SHALL never assert mem_we and mem_oe low in the same cycle.
REQ-025 SHALL hold mem_addr stable from SETUP through HOLD/DONE of a transfer.
REQ-026 SHALL give latency accept(IDLE)->ack of 2+STROBE_CYCLES cycles; one transfer per 3+STROBE_CYCLES cycles maximum.
REQ-027 SHALL ignore a request dropped before ack (protocol violation); transfer in progress still completes and acks.

Reset
REQ-028 SHALL on reset (any state, mid-transfer included) next cycle: state IDLE, mem_we=1, mem_oe=1, mem_data high-Z, wr_ack=0, rd_ack=0, rd_data=0, mem_addr=0, last grant=read (write wins first tie); aborted transfer never acked.

Configuration
REQ-029 SHALL with SRAM_ARB_STATS_EN defined add outputs wr_count, rd_count (16 bits each) counting acked transfers, wrapping 0xFFFF->0x0000, reset to 0.
REQ-030 SHALL without SRAM_ARB_STATS_EN omit those ports and counters; all other behaviour identical.

Structure
REQ-031 SHALL place the FSM state typedef and STROBE_CYCLES default constant in package sram_arb_pkg.
REQ-032 SHALL implement arbitration in sub-module sram_rr_arb (two-way round-robin, registered last-grant).

Verification
REQ-033 SHALL test write then read (STROBE_CYCLES=2): wr 0x0010<-0xBEEF -> mem_we low exactly 2 cycles, wr_ack 4 cycles after accept; rd 0x0010 -> rd_ack with rd_data=0xBEEF.
REQ-034 SHALL test contention: wr_req and rd_req held high from reset -> grants W,R,W,R; no gap beyond one IDLE cycle.
REQ-035 SHALL test reset asserted in 2nd WR_STROBE cycle -> next cycle mem_we=1, bus high-Z, no wr_ack; SRAM word retains last-captured value.
REQ-036 SHALL test STROBE_CYCLES=1 and 15 -> strobe low widths exactly 1 and 15, ack latency 3 and 17.
REQ-037 SHALL assert throughout: no cycle with controller driving and mem_oe=0; never mem_we=0 and mem_oe=0 together.
REQ-038 SHALL test with SRAM_ARB_STATS_EN: 3 writes, 2 reads -> wr_count=3, rd_count=2; preload 0xFFFF then one write -> 0x0000.
